load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/load_extend.sv | 24 ++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, RISC-V width codes
// and the memory dataType codes, plus small decode helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_REFILL,
        S_RESP
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] DT_WORD = 2'b00;
    localparam logic [1:0] DT_BYTE = 2'b01;
    localparam logic [1:0] DT_HALF = 2'b10;

    function automatic logic [1:0] dt_of(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: dt_of = DT_BYTE;
            F3_H, F3_HU: dt_of = DT_HALF;
            default:     dt_of = DT_WORD;
        endcase
    endfunction

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic width_legal(input logic [2:0] funct3, input logic we);
        case (funct3)
            F3_B, F3_H, F3_W: width_legal = 1'b1;
            F3_BU, F3_HU:     width_legal = !we;
            default:          width_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extension: selects the low byte/halfword of the memory
// word and sign- or zero-extends it according to the RISC-V width code.
module load_extend
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3_i,
    input  logic [DATA_WIDTH-1:0] rd_i,
    output logic [DATA_WIDTH-1:0] ext_o
);

    always_comb begin
        ext_o = rd_i;
        case (funct3_i)
            F3_B:  ext_o = {{(DATA_WIDTH-8){rd_i[7]}}, rd_i[7:0]};
            F3_BU: ext_o = {{(DATA_WIDTH-8){1'b0}}, rd_i[7:0]};
            F3_H:  ext_o = {{(DATA_WIDTH-16){rd_i[15]}}, rd_i[15:0]};
            F3_HU: ext_o = {{(DATA_WIDTH-16){1'b0}}, rd_i[15:0]};
            default: ext_o = rd_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a CPU request port and a byte-addressed
// data memory with miss signalling. Define LSU_MISALIGN_CHECK_EN to reject misaligned H/W accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int MISS_PENALTY  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic [ADDRESS_WIDTH-1:0] A,
    output logic                     WE,
    output logic [DATA_WIDTH-1:0]    WD,
    output logic [1:0]               dataType,
    input  logic [DATA_WIDTH-1:0]    RD,
    input  logic                     mem_miss
);

    localparam logic [3:0] REFILL_LAST = 4'(MISS_PENALTY - 1);

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     we_q, we_d;
    logic [2:0]               funct3_q, funct3_d;
    logic                     err_q, err_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [3:0]               cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0]    ext_data;
    logic                     misaligned;
    logic                     req_legal;

    load_extend #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_extend (
        .funct3_i(funct3_q),
        .rd_i    (RD),
        .ext_o   (ext_data)
    );

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = ((dt_of(req_funct3) == DT_HALF) && req_addr[0]) ||
                        ((dt_of(req_funct3) == DT_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_legal = width_legal(req_funct3, req_we) && !misaligned;

    always_comb begin
        // NOTE: every next-state signal takes its held value first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    if (req_legal) begin
                        err_d   = 1'b0;
                        state_d = S_ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    rdata_d = '0;
                    state_d = S_RESP;
                end else if (mem_miss) begin
                    cnt_d   = '0;
                    state_d = S_REFILL;
                end else begin
                    rdata_d = ext_data;
                    state_d = S_RESP;
                end
            end
            S_REFILL: begin
                if (cnt_q == REFILL_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            funct3_q <= F3_W;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    // Memory-side outputs decode straight from state so an async reset drops WE at once.
    logic in_mem;
    assign in_mem     = (state_q == S_ACCESS) || (state_q == S_REFILL);
    assign A          = in_mem ? addr_q : '0;
    assign dataType   = in_mem ? dt_of(funct3_q) : DT_WORD;
    assign WE         = (state_q == S_ACCESS) && we_q;
    assign WD         = (state_q == S_ACCESS) ? wdata_q : '0;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (default parameters, MISS_PENALTY = 2).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] A;
    logic        WE;
    logic [31:0] WD;
    logic [1:0]  dataType;
    logic [31:0] RD;
    logic        mem_miss;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(
        .ADDRESS_WIDTH(16),
        .DATA_WIDTH   (32),
        .MISS_PENALTY (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .A         (A),
        .WE        (WE),
        .WD        (WD),
        .dataType  (dataType),
        .RD        (RD),
        .mem_miss  (mem_miss)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, checks it is accepted, and returns 1 unit after the accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [15:0] addr,
                         input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        check("issue_ready", {31'b0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Load hit: ACCESS cycle checks, then response with the expected extended data.
    task automatic load_hit(input string tag, input logic [2:0] f3, input logic [15:0] addr,
                            input logic [31:0] rd, input logic [1:0] dt, input logic [31:0] exp);
        RD = rd;
        mem_miss = 1'b0;
        issue(1'b0, f3, addr, 32'h0);
        check({tag, "_A"}, {16'b0, A}, {16'b0, addr});
        check({tag, "_dt"}, {30'b0, dataType}, {30'b0, dt});
        check({tag, "_we"}, {31'b0, WE}, 32'd0);
        check({tag, "_early"}, {31'b0, resp_valid}, 32'd0);
        tick();
        check({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, "_err"}, {31'b0, resp_err}, 32'd0);
        check({tag, "_rdata"}, resp_rdata, exp);
        tick();
        check({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_hold"}, resp_rdata, exp);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 16'h0;
        req_wdata  = 32'h0;
        RD         = 32'h0;
        mem_miss   = 1'b0;
        #3;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_err", {31'b0, resp_err}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_A", {16'b0, A}, 32'h0);
        check("rst_WE", {31'b0, WE}, 32'd0);
        check("rst_WD", WD, 32'h0);
        check("rst_dt", {30'b0, dataType}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // SW 0x0010 <- 0xDEADBEEF
        issue(1'b1, 3'b010, 16'h0010, 32'hDEADBEEF);
        check("sw_WE", {31'b0, WE}, 32'd1);
        check("sw_A", {16'b0, A}, 32'h0010);
        check("sw_dt", {30'b0, dataType}, 32'd0);
        check("sw_WD", WD, 32'hDEADBEEF);
        check("sw_early", {31'b0, resp_valid}, 32'd0);
        check("sw_busy", {31'b0, req_ready}, 32'd0);
        tick();
        check("sw_valid", {31'b0, resp_valid}, 32'd1);
        check("sw_err", {31'b0, resp_err}, 32'd0);
        check("sw_rdata", resp_rdata, 32'h0);
        check("sw_WE_off", {31'b0, WE}, 32'd0);
        check("sw_WD_off", WD, 32'h0);
        check("resp_not_ready", {31'b0, req_ready}, 32'd0);
        // A request offered during the response cycle must be ignored.
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 16'h0099;
        tick();
        check("resp_req_dropped_ready", {31'b0, req_ready}, 32'd1);
        check("resp_req_dropped_A", {16'b0, A}, 32'h0);
        req_valid = 1'b0;

        load_hit("lb",  3'b000, 16'h0021, 32'h000000F0, 2'b01, 32'hFFFFFFF0);
        load_hit("lbu", 3'b100, 16'h0021, 32'h000000F0, 2'b01, 32'h000000F0);
        load_hit("lh",  3'b001, 16'h0030, 32'h55558001, 2'b10, 32'hFFFF8001);
        load_hit("lw",  3'b010, 16'h0044, 32'h12345678, 2'b00, 32'h12345678);

        // Illegal width code on a load: immediate error, no memory access, rdata cleared.
        issue(1'b0, 3'b011, 16'h0050, 32'h0);
        check("e011_valid", {31'b0, resp_valid}, 32'd1);
        check("e011_err", {31'b0, resp_err}, 32'd1);
        check("e011_rdata", resp_rdata, 32'h0);
        check("e011_WE", {31'b0, WE}, 32'd0);
        check("e011_A", {16'b0, A}, 32'h0);
        tick();
        check("e011_pulse", {31'b0, resp_valid}, 32'd0);
        check("e011_err_off", {31'b0, resp_err}, 32'd0);

        // LHU with one miss: ACCESS, REFILL x2, ACCESS, RESP (5 edges from accept).
        RD       = 32'h1234ABCD;
        mem_miss = 1'b1;
        issue(1'b0, 3'b101, 16'h0040, 32'h0);
        check("miss_acc1_dt", {30'b0, dataType}, 32'd2);
        check("miss_acc1_WE", {31'b0, WE}, 32'd0);
        tick();
        mem_miss = 1'b0;
        check("miss_ref1_A", {16'b0, A}, 32'h0040);
        check("miss_ref1_dt", {30'b0, dataType}, 32'd2);
        check("miss_ref1_WE", {31'b0, WE}, 32'd0);
        check("miss_ref1_valid", {31'b0, resp_valid}, 32'd0);
        tick();
        check("miss_ref2_A", {16'b0, A}, 32'h0040);
        check("miss_ref2_valid", {31'b0, resp_valid}, 32'd0);
        tick();
        check("miss_acc2_WE", {31'b0, WE}, 32'd0);
        check("miss_acc2_valid", {31'b0, resp_valid}, 32'd0);
        tick();
        check("miss_valid", {31'b0, resp_valid}, 32'd1);
        check("miss_rdata", resp_rdata, 32'h0000ABCD);
        check("miss_err", {31'b0, resp_err}, 32'd0);
        tick();

        // SB passes full wdata unmodified and clears resp_rdata.
        issue(1'b1, 3'b000, 16'h0023, 32'hAABBCCDD);
        check("sb_WE", {31'b0, WE}, 32'd1);
        check("sb_dt", {30'b0, dataType}, 32'd1);
        check("sb_WD", WD, 32'hAABBCCDD);
        tick();
        check("sb_valid", {31'b0, resp_valid}, 32'd1);
        check("sb_rdata", resp_rdata, 32'h0);
        tick();

        // Unsigned width code on a store is illegal.
        issue(1'b1, 3'b100, 16'h0024, 32'h01020304);
        check("sbu_err", {31'b0, resp_err}, 32'd1);
        check("sbu_valid", {31'b0, resp_valid}, 32'd1);
        check("sbu_WE", {31'b0, WE}, 32'd0);
        tick();

        // Misaligned LW: rejected only with the alignment check compiled in.
        RD       = 32'hCAFEF00D;
        mem_miss = 1'b0;
        issue(1'b0, 3'b010, 16'h0002, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        check("mis_valid", {31'b0, resp_valid}, 32'd1);
        check("mis_err", {31'b0, resp_err}, 32'd1);
        check("mis_WE", {31'b0, WE}, 32'd0);
        check("mis_A", {16'b0, A}, 32'h0);
`else
        check("mis_A", {16'b0, A}, 32'h0002);
        check("mis_dt", {30'b0, dataType}, 32'd0);
        tick();
        check("mis_valid", {31'b0, resp_valid}, 32'd1);
        check("mis_err", {31'b0, resp_err}, 32'd0);
        check("mis_rdata", resp_rdata, 32'hCAFEF00D);
`endif
        tick();

        // Reset during REFILL discards the load with no response.
        mem_miss = 1'b1;
        issue(1'b0, 3'b010, 16'h0060, 32'h0);
        tick();
        check("rr_in_refill_A", {16'b0, A}, 32'h0060);
        rst = 1'b1;
        #1;
        check("rr_WE", {31'b0, WE}, 32'd0);
        check("rr_valid", {31'b0, resp_valid}, 32'd0);
        check("rr_A", {16'b0, A}, 32'h0);
        tick();
        rst      = 1'b0;
        mem_miss = 1'b0;
        check("rr_ready_after", {31'b0, req_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rr_no_resp", {31'b0, resp_valid}, 32'd0);
        end

        // Reset during a store ACCESS drops WE without waiting for a clock edge.
        issue(1'b1, 3'b010, 16'h0070, 32'h00000011);
        check("rs_WE_before", {31'b0, WE}, 32'd1);
        rst = 1'b1;
        #1;
        check("rs_WE_dropped", {31'b0, WE}, 32'd0);
        check("rs_WD_dropped", WD, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("rs_no_resp", {31'b0, resp_valid}, 32'd0);
        check("rs_ready", {31'b0, req_ready}, 32'd1);

        // Unit is usable again after the reset.
        load_hit("post_rst_lw", 3'b010, 16'h0080, 32'h0BADCAFE, 2'b00, 32'h0BADCAFE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
